bram_cmd_loader: RTL and testbench
==================================

Name: bram_cmd_loader

Overview:
Byte-stream command front end that sits directly upstream of the 64K x 8 block RAM. It parses write/read commands from an RX byte stream (valid/ready), for example from the UART receiver. It drives the RAM's mode/address/byte_in port, returns read data and status bytes on a TX byte stream (valid/ready), and is the only master of the RAM port.

Parameters:
ADDR_W, 16, RAM address width; address and length fields are ADDR_W bits.
OP_WRITE, 8'h57, opcode 'W'.
OP_READ, 8'h52, opcode 'R'.
RSP_ACK, 8'h4B, 'K', sent after a command completes.
RSP_NAK, 8'h45, 'E', sent for an unknown opcode.

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous, active-low reset
rx_data  in  8  command/data byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader accepts rx byte this cycle
tx_data  out  8  response/read byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink accepts tx byte
mem_mode  out  1  to RAM: 0 read, 1 write
mem_address  out  ADDR_W  to RAM address
mem_byte_in  out  8  to RAM write data
mem_byte_out  in  8  from RAM; registered, valid 1 edge after address/mode=0 sampled
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, tx_valid=0, tx_data=0, mem_mode=0, mem_address=0, mem_byte_in=0, addr/len counters=0. rx_ready=1 follows from IDLE.
- Reset mid-operation aborts the command. A RAM write already registered (mem_mode=1 before the reset edge) commits; no further writes are issued. Partially received bytes are discarded.
- Protocol: opcode, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO. For 'W', LEN data bytes follow. For 'R', LEN data bytes are returned. Both commands then emit RSP_ACK.
- RX transfer = rx_valid & rx_ready at posedge. TX transfer = tx_valid & tx_ready at posedge.
- While tx_valid=1 and tx_ready=0, tx_data is held stable.
- rx_ready=1 only in IDLE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, WR_DATA. It is combinational from state.
- FSM:
  IDLE: on RX, OP_WRITE/OP_READ -> ADDR_HI, latch opcode. Any other byte -> SEND_RSP with RSP_NAK.
  ADDR_HI -> ADDR_LO -> LEN_HI -> LEN_LO: latch each byte on RX.
  LEN_LO on RX: len==0 -> SEND_RSP(ACK). Otherwise 'W' -> WR_DATA, 'R' -> RD_ISSUE.
  WR_DATA on RX: register mem_mode<=1, mem_address<=addr, mem_byte_in<=rx_data. Then addr<=addr+1, len<=len-1. After the last byte -> SEND_RSP(ACK). The RAM commits on the following edge.
  RD_ISSUE: mem_mode<=0, mem_address<=addr -> RD_WAIT.
  RD_WAIT: RAM samples the address -> RD_CAP.
  RD_CAP: tx_data<=mem_byte_out, tx_valid<=1 -> RD_SEND.
  RD_SEND on TX: tx_valid<=0, addr++, len--. If len was 1 -> SEND_RSP(ACK), else -> RD_ISSUE.
  SEND_RSP: tx_data=response, tx_valid=1. On TX -> IDLE.
- mem_mode defaults to 0 every cycle unless a WR_DATA accept occurs, so it is a single-cycle pulse per byte. Back-to-back accepts give back-to-back writes (1 byte/cycle).
- Read throughput: 1 byte per 4 cycles with tx_ready tied high.
- Address arithmetic is modulo 2^ADDR_W: 0xFFFF+1 wraps to 0x0000. Length is unsigned 16-bit, max 65535.
- No timeout: a stalled command waits indefinitely for RX bytes.
- busy=1 whenever state != IDLE.

Decomposition:
- Package bram_loader_pkg holds the opcode constants, the RSP_ACK/RSP_NAK constants, and the state enum (IDLE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, WR_DATA, RD_ISSUE, RD_WAIT, RD_CAP, RD_SEND, SEND_RSP).
- Single module with no sub-module. The bench instantiates the existing RAM behind it.

Test Plan:
- RX 57 12 34 00 02 AA 55 -> RAM[0x1234]=AA, RAM[0x1235]=55, exactly two mem_mode pulses, then TX 4B.
- After the above, RX 52 12 34 00 02 -> TX AA, 55, 4B in order; no mem_mode=1 during the read.
- Wrap: RX 57 FF FF 00 02 11 22, then read 0xFFFF len 2 -> RAM[0xFFFF]=11, RAM[0x0000]=22; read returns 11 22 4B.
- RX 00 -> TX 45, state IDLE, busy=0. Then RX 57 00 00 00 00 -> TX 4B with no RAM write.
- Backpressure: during a read, hold tx_ready=0 for 10 cycles -> tx_valid=1 and tx_data constant throughout, with no byte lost or duplicated.
- Reset mid-write: after 57 00 10 00 04 AA BB, pulse rst_n low one cycle -> RAM[0x0010..0x0011]=AA BB, RAM[0x0012..0x0013] unchanged, no TX, then a new command is accepted normally.

Source files
------------

// File: rtl/bram_loader_pkg.sv
// rtl/bram_loader_pkg.sv - shared constants and state encoding for the BRAM command loader
//
// Contents:
//   ADDR_W            RAM address / length field width
//   OP_WRITE, OP_READ command opcodes ('W', 'R')
//   RSP_ACK, RSP_NAK  response bytes ('K', 'E')
//   loader_state_e    loader FSM states
//   is_known_op()     opcode decode helper
package bram_loader_pkg;

  localparam int unsigned ADDR_W = 16;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h4B;
  localparam logic [7:0] RSP_NAK  = 8'h45;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    LEN_HI,
    LEN_LO,
    WR_DATA,
    RD_ISSUE,
    RD_WAIT,
    RD_CAP,
    RD_SEND,
    SEND_RSP
  } loader_state_e;

  function automatic logic is_known_op(input logic [7:0] b);
    return (b == OP_WRITE) || (b == OP_READ);
  endfunction

endpackage

// File: rtl/bram_cmd_loader.sv
// rtl/bram_cmd_loader.sv - byte-stream write/read command front end for a 64K x 8 block RAM
//
// Ports:
//   clk            system clock, all logic on posedge
//   rst_n          synchronous active-low reset
//   rx_data/rx_valid/rx_ready   command/data byte stream in
//   tx_data/tx_valid/tx_ready   read data / response byte stream out
//   mem_mode       to RAM: 0 read, 1 write (single-cycle pulse per written byte)
//   mem_address    to RAM address
//   mem_byte_in    to RAM write data
//   mem_byte_out   from RAM, registered one edge after the address is sampled
//   busy           high whenever the loader is not idle
module bram_cmd_loader
  import bram_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              mem_mode,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_byte_in,
  input  logic [7:0]        mem_byte_out,
  output logic              busy
);

  loader_state_e     state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              mem_mode_q, mem_mode_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [7:0]        mem_byte_in_q, mem_byte_in_d;

  logic              rx_fire;
  logic              tx_fire;
  logic [ADDR_W-1:0] len_full;

  always_comb begin
    rx_ready = (state_q == IDLE)   || (state_q == ADDR_HI) ||
               (state_q == ADDR_LO) || (state_q == LEN_HI)  ||
               (state_q == LEN_LO)  || (state_q == WR_DATA);
  end

  assign rx_fire  = rx_valid & rx_ready;
  assign tx_fire  = tx_valid_q & tx_ready;
  // Length as it will be once the low byte currently on rx_data is latched.
  assign len_full = {len_q[ADDR_W-1:8], rx_data};

  always_comb begin
    state_d       = state_q;
    is_wr_d       = is_wr_q;
    addr_d        = addr_q;
    len_d         = len_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    mem_mode_d    = 1'b0;
    mem_address_d = mem_address_q;
    mem_byte_in_d = mem_byte_in_q;

    case (state_q)
      IDLE: begin
        if (rx_fire) begin
          if (is_known_op(rx_data)) begin
            is_wr_d = (rx_data == OP_WRITE);
            state_d = ADDR_HI;
          end else begin
            tx_data_d  = RSP_NAK;
            tx_valid_d = 1'b1;
            state_d    = SEND_RSP;
          end
        end
      end
      ADDR_HI: begin
        if (rx_fire) begin
          addr_d  = {rx_data, addr_q[7:0]};
          state_d = ADDR_LO;
        end
      end
      ADDR_LO: begin
        if (rx_fire) begin
          addr_d  = {addr_q[ADDR_W-1:8], rx_data};
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        if (rx_fire) begin
          len_d   = {rx_data, len_q[7:0]};
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (rx_fire) begin
          len_d = len_full;
          if (len_full == '0) begin
            tx_data_d  = RSP_ACK;
            tx_valid_d = 1'b1;
            state_d    = SEND_RSP;
          end else if (is_wr_q) begin
            state_d = WR_DATA;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end
      WR_DATA: begin
        if (rx_fire) begin
          // The RAM commits this byte on the edge after it is registered here.
          mem_mode_d    = 1'b1;
          mem_address_d = addr_q;
          mem_byte_in_d = rx_data;
          addr_d        = addr_q + ADDR_W'(1);
          len_d         = len_q - ADDR_W'(1);
          if (len_q == ADDR_W'(1)) begin
            tx_data_d  = RSP_ACK;
            tx_valid_d = 1'b1;
            state_d    = SEND_RSP;
          end
        end
      end
      RD_ISSUE: begin
        mem_address_d = addr_q;
        state_d       = RD_WAIT;
      end
      RD_WAIT: begin
        // RAM samples mem_address on this edge; data appears in RD_CAP.
        state_d = RD_CAP;
      end
      RD_CAP: begin
        tx_data_d  = mem_byte_out;
        tx_valid_d = 1'b1;
        state_d    = RD_SEND;
      end
      RD_SEND: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          addr_d     = addr_q + ADDR_W'(1);
          len_d      = len_q - ADDR_W'(1);
          if (len_q == ADDR_W'(1)) begin
            tx_data_d  = RSP_ACK;
            tx_valid_d = 1'b1;
            state_d    = SEND_RSP;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end
      SEND_RSP: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      is_wr_q       <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      mem_mode_q    <= 1'b0;
      mem_address_q <= '0;
      mem_byte_in_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      is_wr_q       <= is_wr_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      mem_mode_q    <= mem_mode_d;
      mem_address_q <= mem_address_d;
      mem_byte_in_q <= mem_byte_in_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign mem_mode    = mem_mode_q;
  assign mem_address = mem_address_q;
  assign mem_byte_in = mem_byte_in_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_bram_cmd_loader.sv
// tb/tb_bram_cmd_loader.sv - directed self-checking bench for bram_cmd_loader with a 64K x 8 RAM model
module tb_bram_cmd_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mem_mode;
  logic [15:0] mem_address;
  logic [7:0]  mem_byte_in;
  logic [7:0]  mem_byte_out;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [7:0] txq[$];
  logic [7:0] ram [0:65535];
  logic [7:0] held;

  bram_cmd_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .mem_mode     (mem_mode),
    .mem_address  (mem_address),
    .mem_byte_in  (mem_byte_in),
    .mem_byte_out (mem_byte_out),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block RAM model: registered read, write on mem_mode=1.
  always @(posedge clk) begin
    if (mem_mode) ram[mem_address] <= mem_byte_in;
    mem_byte_out <= ram[mem_address];
  end

  // Monitors sample at the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (mem_mode) wr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; leaves rx_valid high so consecutive calls stream back-to-back.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("rx_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic rx_stop();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [15:0] a, input logic [15:0] l);
    send_byte(op);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(l[15:8]);
    send_byte(l[7:0]);
  endtask

  task automatic wait_tx(input int n);
    int c;
    c = 0;
    while (txq.size() < n && c < 500) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= 500) check("tx_wait_timeout", 32'(txq.size()), 32'(n));
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] txq_at(input int i);
    if (i < txq.size()) return txq[i];
    return 8'hXX;
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0012] = 8'hC3;
    ram[16'h0013] = 8'h3C;
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_mem_mode", 32'(mem_mode), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'h0000);
    check("rst_mem_byte_in", 32'(mem_byte_in), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write two bytes at 0x1234.
    txq.delete(); wr_cnt = 0;
    send_cmd(8'h57, 16'h1234, 16'h0002);
    send_byte(8'hAA);
    send_byte(8'h55);
    rx_stop();
    wait_tx(1);
    check("wr_ram_1234", 32'(ram[16'h1234]), 32'hAA);
    check("wr_ram_1235", 32'(ram[16'h1235]), 32'h55);
    check("wr_pulses", 32'(wr_cnt), 32'd2);
    check("wr_tx_count", 32'(txq.size()), 32'd1);
    check("wr_ack", 32'(txq_at(0)), 32'h4B);
    check("wr_idle", 32'(busy), 32'd0);

    // Read them back.
    txq.delete(); wr_cnt = 0;
    send_cmd(8'h52, 16'h1234, 16'h0002);
    rx_stop();
    wait_tx(3);
    check("rd_count", 32'(txq.size()), 32'd3);
    check("rd_b0", 32'(txq_at(0)), 32'hAA);
    check("rd_b1", 32'(txq_at(1)), 32'h55);
    check("rd_ack", 32'(txq_at(2)), 32'h4B);
    check("rd_no_write", 32'(wr_cnt), 32'd0);

    // Address wrap at 0xFFFF.
    txq.delete(); wr_cnt = 0;
    send_cmd(8'h57, 16'hFFFF, 16'h0002);
    send_byte(8'h11);
    send_byte(8'h22);
    rx_stop();
    wait_tx(1);
    check("wrap_ack", 32'(txq_at(0)), 32'h4B);
    check("wrap_ram_ffff", 32'(ram[16'hFFFF]), 32'h11);
    check("wrap_ram_0000", 32'(ram[16'h0000]), 32'h22);
    txq.delete();
    send_cmd(8'h52, 16'hFFFF, 16'h0002);
    rx_stop();
    wait_tx(3);
    check("wrap_rd_count", 32'(txq.size()), 32'd3);
    check("wrap_rd_b0", 32'(txq_at(0)), 32'h11);
    check("wrap_rd_b1", 32'(txq_at(1)), 32'h22);
    check("wrap_rd_ack", 32'(txq_at(2)), 32'h4B);

    // Unknown opcode, then zero-length write.
    txq.delete(); wr_cnt = 0;
    send_byte(8'h00);
    rx_stop();
    wait_tx(1);
    check("nak_count", 32'(txq.size()), 32'd1);
    check("nak_byte", 32'(txq_at(0)), 32'h45);
    check("nak_idle", 32'(busy), 32'd0);
    txq.delete();
    send_cmd(8'h57, 16'h0000, 16'h0000);
    rx_stop();
    wait_tx(1);
    check("zlen_ack", 32'(txq_at(0)), 32'h4B);
    check("zlen_no_write", 32'(wr_cnt), 32'd0);
    check("zlen_ram_0000", 32'(ram[16'h0000]), 32'h22);

    // Backpressure during a read.
    txq.delete();
    tx_ready = 1'b0;
    send_cmd(8'h52, 16'h1234, 16'h0002);
    rx_stop();
    begin
      int c;
      c = 0;
      while (!tx_valid && c < 100) begin
        @(posedge clk); #1;
        c++;
      end
      check("bp_valid_seen", 32'(tx_valid), 32'd1);
    end
    held = tx_data;
    check("bp_first_byte", 32'(held), 32'hAA);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 32'(tx_valid), 32'd1);
      check("bp_hold_data", 32'(tx_data), 32'(held));
    end
    check("bp_nothing_sent", 32'(txq.size()), 32'd0);
    tx_ready = 1'b1;
    wait_tx(3);
    check("bp_count", 32'(txq.size()), 32'd3);
    check("bp_b0", 32'(txq_at(0)), 32'hAA);
    check("bp_b1", 32'(txq_at(1)), 32'h55);
    check("bp_ack", 32'(txq_at(2)), 32'h4B);

    // Reset in the middle of a 4-byte write.
    txq.delete(); wr_cnt = 0;
    send_cmd(8'h57, 16'h0010, 16'h0004);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rx_stop();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rstw_ram_0010", 32'(ram[16'h0010]), 32'hAA);
    check("rstw_ram_0011", 32'(ram[16'h0011]), 32'hBB);
    check("rstw_ram_0012", 32'(ram[16'h0012]), 32'hC3);
    check("rstw_ram_0013", 32'(ram[16'h0013]), 32'h3C);
    check("rstw_pulses", 32'(wr_cnt), 32'd2);
    check("rstw_no_tx", 32'(txq.size()), 32'd0);
    check("rstw_idle", 32'(busy), 32'd0);
    send_cmd(8'h52, 16'h0010, 16'h0004);
    rx_stop();
    wait_tx(5);
    check("rstw_rd_count", 32'(txq.size()), 32'd5);
    check("rstw_rd_b0", 32'(txq_at(0)), 32'hAA);
    check("rstw_rd_b1", 32'(txq_at(1)), 32'hBB);
    check("rstw_rd_b2", 32'(txq_at(2)), 32'hC3);
    check("rstw_rd_b3", 32'(txq_at(3)), 32'h3C);
    check("rstw_rd_ack", 32'(txq_at(4)), 32'h4B);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
